alu_op_issue: RTL and testbench

//  Issue stage feeding the ALU: accepts one RV32I instruction plus register-file operands per

---
 rtl/alu_issue_pkg.sv | 45 ++++
 rtl/alu_op_decode.sv | 126 ++++++++++++
 rtl/alu_op_issue.sv | 104 ++++++++++
 tb/tb_alu_op_issue.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, RV32I
// opcode constants, the issue-entry record and the skid occupancy states.
package alu_issue_pkg;

    localparam int unsigned ISSUE_XLEN = 32;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_XOR     = 4'b0010;
    localparam logic [3:0] ALU_AND     = 4'b0011;
    localparam logic [3:0] ALU_OR      = 4'b0100;
    localparam logic [3:0] ALU_SLL     = 4'b0101;
    localparam logic [3:0] ALU_SRL     = 4'b0110;
    localparam logic [3:0] ALU_ILLEGAL = 4'hF;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [ISSUE_XLEN-1:0] a;
        logic [ISSUE_XLEN-1:0] b;
        logic [3:0]            alu_ctrl;
        logic [4:0]            rd;
        logic                  rd_we;
        logic                  illegal;
    } issue_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    // Sign-extend a 12-bit immediate to the datapath width.
    function automatic logic [ISSUE_XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(ISSUE_XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode into an ALU issue entry.
// Build option: define ALU_OP_ISSUE_BRANCH_EN to decode beq/bne as a subtract
// (consumer branches on the zero flag); otherwise every BRANCH is illegal.
module alu_op_decode
    import alu_issue_pkg::*;
#(
    parameter logic [3:0] ILLEGAL_CTRL = ALU_ILLEGAL
) (
    input  logic [31:0]           instr,
    input  logic [ISSUE_XLEN-1:0] rs1_data,
    input  logic [ISSUE_XLEN-1:0] rs2_data,
    output issue_entry_t          entry
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [ISSUE_XLEN-1:0] imm_i;
    logic [ISSUE_XLEN-1:0] imm_s;
    logic [ISSUE_XLEN-1:0] shamt;
    logic       unused_rs1_field;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = sext12(instr[31:20]);
    assign imm_s  = sext12({instr[31:25], instr[11:7]});
    assign shamt  = {{(ISSUE_XLEN-5){1'b0}}, instr[24:20]};
    // rs1 index is resolved upstream; only its data reaches this stage.
    assign unused_rs1_field = &{1'b0, instr[19:15]};

    logic                  legal;
    logic [3:0]            ctrl;
    logic [ISSUE_XLEN-1:0] b_sel;
    logic                  we;

    // Classify the instruction and pick control code, operand b and write enable.
    always_comb begin
        legal = 1'b0;
        ctrl  = ILLEGAL_CTRL;
        b_sel = rs2_data;
        we    = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                we = 1'b1;
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  ctrl = ALU_ADD;
                        3'b100:  ctrl = ALU_XOR;
                        3'b111:  ctrl = ALU_AND;
                        3'b110:  ctrl = ALU_OR;
                        3'b001:  ctrl = ALU_SLL;
                        3'b101:  ctrl = ALU_SRL;
                        default: legal = 1'b0;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    legal = 1'b1;
                    ctrl  = ALU_SUB;
                end
            end
            OPC_OPIMM: begin
                we    = 1'b1;
                b_sel = imm_i;
                legal = 1'b1;
                case (funct3)
                    3'b000: ctrl = ALU_ADD;
                    3'b100: ctrl = ALU_XOR;
                    3'b111: ctrl = ALU_AND;
                    3'b110: ctrl = ALU_OR;
                    3'b001: begin
                        ctrl  = ALU_SLL;
                        b_sel = shamt;
                        legal = (funct7 == F7_BASE);
                    end
                    3'b101: begin
                        ctrl  = ALU_SRL;
                        b_sel = shamt;
                        legal = (funct7 == F7_BASE);
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                legal = 1'b1;
                ctrl  = ALU_ADD;
                b_sel = imm_i;
                we    = 1'b1;
            end
            OPC_STORE: begin
                legal = 1'b1;
                ctrl  = ALU_ADD;
                b_sel = imm_s;
                we    = 1'b0;
            end
`ifdef ALU_OP_ISSUE_BRANCH_EN
            OPC_BRANCH: begin
                ctrl  = ALU_SUB;
                b_sel = rs2_data;
                we    = 1'b0;
                legal = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
`endif
            default: legal = 1'b0;
        endcase
    end

    // Illegal instructions still issue, with rs2 as b and no writeback.
    always_comb begin
        entry          = '0;
        entry.a        = rs1_data;
        entry.rd       = instr[11:7];
        if (legal) begin
            entry.b        = b_sel;
            entry.alu_ctrl = ctrl;
            entry.rd_we    = we;
            entry.illegal  = 1'b0;
        end else begin
            entry.b        = rs2_data;
            entry.alu_ctrl = ILLEGAL_CTRL;
            entry.rd_we    = 1'b0;
            entry.illegal  = 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_issue.sv
// ALU issue stage: decode plus a registered 2-entry skid buffer.
// Build option: ALU_OP_ISSUE_BRANCH_EN (see alu_op_decode).
//
// state     | meaning
// OCC_EMPTY | no entry held, out_valid=0, in_ready=1
// OCC_ONE   | entry0 (output register) held, in_ready=1
// OCC_TWO   | entry0 and entry1 (skid) held, in_ready=0
module alu_op_issue
    import alu_issue_pkg::*;
#(
    // Datapath width is fixed by the issue-entry record in the package.
    parameter int unsigned XLEN         = ISSUE_XLEN,
    parameter logic [3:0]  ILLEGAL_CTRL = ALU_ILLEGAL
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [3:0]      ALU_ctrl,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            illegal
);

    issue_entry_t dec;
    issue_entry_t entry0;
    issue_entry_t entry1;
    occ_t         occ;
    logic         accept;
    logic         emit;

    alu_op_decode #(
        .ILLEGAL_CTRL (ILLEGAL_CTRL)
    ) u_decode (
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .entry    (dec)
    );

    // Handshakes use only registered flags, so in_ready never sees out_ready.
    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    // Occupancy FSM: moves entries through the output register and skid slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ       <= OCC_EMPTY;
            entry0    <= '0;
            entry1    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (occ)
                OCC_EMPTY: begin
                    if (accept) begin
                        entry0    <= dec;
                        occ       <= OCC_ONE;
                        out_valid <= 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && emit) begin
                        entry0 <= dec;
                    end else if (accept) begin
                        entry1   <= dec;
                        occ      <= OCC_TWO;
                        in_ready <= 1'b0;
                    end else if (emit) begin
                        occ       <= OCC_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                OCC_TWO: begin
                    if (emit) begin
                        entry0   <= entry1;
                        occ      <= OCC_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    occ       <= OCC_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign a        = entry0.a;
    assign b        = entry0.b;
    assign ALU_ctrl = entry0.alu_ctrl;
    assign rd       = entry0.rd;
    assign rd_we    = entry0.rd_we;
    assign illegal  = entry0.illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_alu_op_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ALU_ctrl;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_op_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .ALU_ctrl  (ALU_ctrl),
        .rd        (rd),
        .rd_we     (rd_we),
        .illegal   (illegal)
    );

    // Packed view {a,b,ALU_ctrl,rd,rd_we,illegal}
    wire [74:0] obs = {a, b, ALU_ctrl, rd, rd_we, illegal};

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3,
                                          input logic [4:0] d, input logic [6:0] op);
        return {f7, s2, s1, f3, d, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] d,
                                          input logic [6:0] op);
        return {imm, s1, f3, d, op};
    endfunction

    // Reference: what the ALU should be told for this instruction.
    function automatic logic [74:0] ref_issue(input logic [31:0] ins, input logic [31:0] r1,
                                              input logic [31:0] r2);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          ctrl;
        logic [31:0] bv;
        logic        we;
        int          imm_i;
        int          imm_s;
        op    = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = int'($signed(ins[31:20]));
        imm_s = int'($signed({ins[31:25], ins[11:7]}));
        ctrl  = -1;
        bv    = r2;
        we    = 1'b0;
        if (op == 7'h33) begin
            we = 1'b1;
            if (f7 == 7'h00 && f3 == 3'd0) ctrl = 0;
            if (f7 == 7'h20 && f3 == 3'd0) ctrl = 1;
            if (f7 == 7'h00 && f3 == 3'd4) ctrl = 2;
            if (f7 == 7'h00 && f3 == 3'd7) ctrl = 3;
            if (f7 == 7'h00 && f3 == 3'd6) ctrl = 4;
            if (f7 == 7'h00 && f3 == 3'd1) ctrl = 5;
            if (f7 == 7'h00 && f3 == 3'd5) ctrl = 6;
        end else if (op == 7'h13) begin
            we = 1'b1;
            bv = imm_i;
            if (f3 == 3'd0) ctrl = 0;
            if (f3 == 3'd4) ctrl = 2;
            if (f3 == 3'd7) ctrl = 3;
            if (f3 == 3'd6) ctrl = 4;
            if (f7 == 7'h00 && (f3 == 3'd1 || f3 == 3'd5)) begin
                ctrl = (f3 == 3'd1) ? 5 : 6;
                bv   = 32'(ins[24:20]);
            end
        end else if (op == 7'h03) begin
            ctrl = 0; bv = imm_i; we = 1'b1;
        end else if (op == 7'h23) begin
            ctrl = 0; bv = imm_s; we = 1'b0;
        end
`ifdef ALU_OP_ISSUE_BRANCH_EN
        else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
            ctrl = 1; bv = r2; we = 1'b0;
        end
`endif
        if (ctrl < 0) return {r1, r2, 4'hF, ins[11:7], 1'b0, 1'b1};
        return {r1, bv, 4'(ctrl), ins[11:7], we, 1'b0};
    endfunction

    task automatic drive_idle();
        in_valid  = 1'b0;
        instr     = 32'h0;
        rs1_data  = 32'h0;
        rs2_data  = 32'h0;
        out_ready = 1'b1;
    endtask

    task automatic drain();
        drive_idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({out_valid, in_ready, obs} !== {1'b0, 1'b1, 75'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b r=%b obs=%h, want v=0 r=1 obs=0", out_valid, in_ready, obs);
        end
    endtask

    task automatic test_add();
        logic [31:0] ins;
        ins = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
        in_valid = 1'b1; instr = ins; rs1_data = 32'd5; rs2_data = 32'd7; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, obs} !== {1'b1, 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_basic: got v=%b obs=%h, want v=1 a=5 b=7 ctrl=0 rd=3 we=1", out_valid, obs);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; out_ready = 1'b1;
        instr = enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13); rs1_data = 32'd0; rs2_data = 32'h1234;
        @(negedge clk);
        n_checks++;
        if ({out_valid, b, ALU_ctrl, rd} !== {1'b1, 32'hFFFF_FFFF, 4'b0000, 5'd1}) begin
            n_fail++;
            $display("FAIL b2b_addi: got v=%b b=%h ctrl=%h rd=%0d, want b=ffffffff ctrl=0 rd=1", out_valid, b, ALU_ctrl, rd);
        end
        instr = enc_i(12'h004, 5'd1, 3'd5, 5'd2, 7'h13); rs1_data = 32'hFFFF_FFFF; rs2_data = 32'h55;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, a, b, ALU_ctrl, rd, rd_we} !== {1'b1, 32'hFFFF_FFFF, 32'd4, 4'b0110, 5'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_srli: got v=%b a=%h b=%h ctrl=%h rd=%0d we=%b, want b=4 ctrl=6 rd=2", out_valid, a, b, ALU_ctrl, rd, rd_we);
        end
        drain();
    endtask

    task automatic test_skid();
        logic [31:0] ins [3];
        logic [74:0] exp [3];
        for (int i = 0; i < 3; i++) begin
            ins[i] = enc_r(7'h00, 5'(i + 4), 5'(i + 1), 3'd4, 5'(i + 10), 7'h33);
            exp[i] = ref_issue(ins[i], 32'(100 + i), 32'(200 + i));
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = ins[i]; rs1_data = 32'(100 + i); rs2_data = 32'(200 + i);
            n_checks++;
            if (in_ready !== (i < 2)) begin
                n_fail++;
                $display("FAIL skid_in_ready_%0d: got %b want %b", i, in_ready, (i < 2));
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, obs} !== {1'b1, 1'b0, exp[0]}) begin
            n_fail++;
            $display("FAIL skid_hold: got v=%b r=%b obs=%h want v=1 r=0 obs=%h", out_valid, in_ready, obs, exp[0]);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, obs} !== {1'b1, 1'b1, exp[1]}) begin
            n_fail++;
            $display("FAIL skid_second: got v=%b r=%b obs=%h want v=1 r=1 obs=%h", out_valid, in_ready, obs, exp[1]);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL skid_empty: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        drain();
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; out_ready = 1'b1;
        instr = enc_i({7'b0100000, 5'd3}, 5'd6, 3'd5, 5'd8, 7'h13);
        rs1_data = 32'hDEAD_0000; rs2_data = 32'h0000_BEEF;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL srai_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, obs} !== {1'b1, 32'hDEAD_0000, 32'h0000_BEEF, 4'hF, 5'd8, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL srai_illegal: got v=%b obs=%h want illegal ctrl=f we=0 b=rs2", out_valid, obs);
        end
        drain();
    endtask

    task automatic test_branch();
        logic [74:0] want;
`ifdef ALU_OP_ISSUE_BRANCH_EN
        want = {32'd9, 32'd9, 4'b0001, 5'b00100, 1'b0, 1'b0};
`else
        want = {32'd9, 32'd9, 4'hF, 5'b00100, 1'b0, 1'b1};
`endif
        in_valid = 1'b1; out_ready = 1'b1;
        instr = {7'b0000000, 5'd2, 5'd1, 3'd0, 5'b00100, 7'h63};
        rs1_data = 32'd9; rs2_data = 32'd9;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, obs} !== {1'b1, want}) begin
            n_fail++;
            $display("FAIL beq_decode: got v=%b obs=%h want v=1 obs=%h", out_valid, obs, want);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            instr = enc_r(7'h00, 5'd1, 5'd2, 3'd7, 5'(i + 20), 7'h33);
            rs1_data = 32'hA5A5_0000 + i; rs2_data = 32'h5A5A;
            @(negedge clk);
        end
        n_checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_mid_full: got v=%b r=%b want v=1 r=0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, obs} !== {1'b0, 1'b1, 75'h0}) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got v=%b r=%b obs=%h want v=0 r=1 obs=0", out_valid, in_ready, obs);
        end
        drain();
    endtask

    task automatic test_random();
        logic [74:0] q[$];
        logic [6:0]  ops [8];
        logic [6:0]  f7s [4];
        logic [31:0] ins;
        logic        acc;
        logic        emi;
        ops = '{7'h33, 7'h33, 7'h13, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37};
        f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
        for (int cyc = 0; cyc < 600; cyc++) begin
            n_checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_flags cyc %0d: got v=%b r=%b want occupancy %0d", cyc, out_valid, in_ready, q.size());
            end
            if (q.size() > 0) begin
                n_checks++;
                if (obs !== q[0]) begin
                    n_fail++;
                    $display("FAIL rand_data cyc %0d: got %h want %h", cyc, obs, q[0]);
                end
            end
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 7)];
            ins[31:25] = ($urandom_range(0, 4) == 0) ? 7'($urandom) : f7s[$urandom_range(0, 3)];
            instr     = ins;
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            acc = in_valid && (q.size() < 2);
            emi = out_ready && (q.size() > 0);
            if (emi) void'(q.pop_front());
            if (acc) q.push_back(ref_issue(ins, rs1_data, rs2_data));
            @(negedge clk);
        end
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_add();
        test_back_to_back();
        test_skid();
        test_illegal();
        test_branch();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
